// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-side registered outputs,
// hazard stall and performance counters. master = upstream/driver, slave = stage.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic            id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_branch;
  logic [1:0]      id_alu_op;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic            ex_flush;

  logic            ex_valid;
  logic            ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch;
  logic [1:0]      ex_alu_op;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic            stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src,
           id_branch, id_alu_op, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
           id_rs1_data, id_rs2_data, id_imm, id_pc, ex_flush,
    input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
           ex_branch, ex_alu_op, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src,
           id_branch, id_alu_op, id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
           id_rs1_data, id_rs2_data, id_imm, id_pc, ex_flush,
    output ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
           ex_branch, ex_alu_op, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } data_t;

  ctrl_t id_ctrl, ctrl_q;
  data_t id_data, data_q;
  logic  vld_q;
  logic  hz, capture;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign id_ctrl = {bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_read, bus.id_mem_write,
                    bus.id_alu_src, bus.id_branch, bus.id_alu_op};
  assign id_data = {bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7b5,
                    bus.id_rs1_data, bus.id_rs2_data, bus.id_imm, bus.id_pc};

  // rs2 is compared even for I-type; a spurious stall is cheaper than decoding format here
  assign hz = bus.id_valid & vld_q & ctrl_q.mem_read & (data_q.rd != '0) &
              ((data_q.rd == bus.id_rs1) | (data_q.rd == bus.id_rs2));

  // a flushed decode slot is being killed upstream, so holding it is pointless
  assign bus.stall = hz & ~bus.ex_flush & ~rst;
  assign capture   = ~bus.ex_flush & ~hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= capture & bus.id_valid;
      ctrl_q <= (capture & bus.id_valid) ? id_ctrl : '0;
      data_q <= capture ? id_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.ex_flush) begin
      flush_cnt_q <= sat_inc(flush_cnt_q);
    end else if (hz) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.ex_valid      = vld_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.ex_rs1        = data_q.rs1;
  assign bus.ex_rs2        = data_q.rs2;
  assign bus.ex_rd         = data_q.rd;
  assign bus.ex_funct3     = data_q.funct3;
  assign bus.ex_funct7b5   = data_q.funct7b5;
  assign bus.ex_rs1_data   = data_q.rs1_data;
  assign bus.ex_rs2_data   = data_q.rs2_data;
  assign bus.ex_imm        = data_q.imm;
  assign bus.ex_pc         = data_q.pc;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a wide-counter and a 2-bit-counter instance
// share stimulus; a monitor compares each cycle against a queued expectation.
module tb_id_ex_stage;
  typedef struct packed {
    logic        valid, rw, m2r, mr, mw, as, br;
    logic [1:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] d1, d2, imm, pc;
  } ins_t;

  typedef struct {
    logic stall;
    ins_t ex;
    logic chk_data;
    int   sc;
    int   fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ins_t din = '0;
  logic fin = 1'b0;
  ins_t got, sgot;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  sbus ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(sbus.slave));

  assign {bus.id_valid, bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_read, bus.id_mem_write,
          bus.id_alu_src, bus.id_branch, bus.id_alu_op, bus.id_rs1, bus.id_rs2, bus.id_rd,
          bus.id_funct3, bus.id_funct7b5, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
          bus.id_pc, bus.ex_flush} = {din, fin};
  assign {sbus.id_valid, sbus.id_reg_write, sbus.id_mem_to_reg, sbus.id_mem_read, sbus.id_mem_write,
          sbus.id_alu_src, sbus.id_branch, sbus.id_alu_op, sbus.id_rs1, sbus.id_rs2, sbus.id_rd,
          sbus.id_funct3, sbus.id_funct7b5, sbus.id_rs1_data, sbus.id_rs2_data, sbus.id_imm,
          sbus.id_pc, sbus.ex_flush} = {din, fin};
  assign got = {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_alu_src, bus.ex_branch, bus.ex_alu_op, bus.ex_rs1, bus.ex_rs2, bus.ex_rd,
                bus.ex_funct3, bus.ex_funct7b5, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_pc};
  assign sgot = {sbus.ex_valid, sbus.ex_reg_write, sbus.ex_mem_to_reg, sbus.ex_mem_read, sbus.ex_mem_write,
                 sbus.ex_alu_src, sbus.ex_branch, sbus.ex_alu_op, sbus.ex_rs1, sbus.ex_rs2, sbus.ex_rd,
                 sbus.ex_funct3, sbus.ex_funct7b5, sbus.ex_rs1_data, sbus.ex_rs2_data, sbus.ex_imm, sbus.ex_pc};

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // reference state: what EX should hold, and how many events have occurred
  ins_t m_ex = '0;
  int   m_sc = 0;
  int   m_fc = 0;
  logic last_stall = 1'b0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, x, $time);
    end
  endtask

  task automatic step(input ins_t d, input logic fl, input logic r);
    exp_t e;
    logic hz;
    @(negedge clk);
    din = d;
    fin = fl;
    rst = r;
    #1;
    if (r) begin
      e.stall = 1'b0;
      m_ex = '0;
      m_sc = 0;
      m_fc = 0;
      e.chk_data = 1'b1;
    end else begin
      hz = d.valid && m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) &&
           ((m_ex.rd == d.rs1) || (m_ex.rd == d.rs2));
      e.stall = hz && !fl;
      if (fl) begin
        m_ex = '0; m_fc++; e.chk_data = 1'b0;
      end else if (hz) begin
        m_ex = '0; m_sc++; e.chk_data = 1'b0;
      end else begin
        m_ex = d;
        e.chk_data = 1'b1;
        if (!d.valid) {m_ex.rw, m_ex.m2r, m_ex.mr, m_ex.mw, m_ex.as, m_ex.br, m_ex.op} = '0;
      end
    end
    e.ex = m_ex;
    e.sc = m_sc;
    e.fc = m_fc;
    last_stall = e.stall;
    q.push_back(e);
  endtask

  function automatic ins_t rand_ins();
    ins_t d;
    d.valid = ($urandom_range(0, 99) < 85);
    d.rw  = 1'($urandom); d.m2r = 1'($urandom);
    d.mr  = ($urandom_range(0, 1) == 1);
    d.mw  = 1'($urandom); d.as = 1'($urandom); d.br = 1'($urandom);
    d.op  = 2'($urandom);
    d.rs1 = 5'($urandom_range(0, 7));
    d.rs2 = 5'($urandom_range(0, 7));
    d.rd  = 5'($urandom_range(0, 7));
    d.f3  = 3'($urandom); d.f7 = 1'($urandom);
    d.d1  = $urandom; d.d2 = $urandom; d.imm = $urandom; d.pc = $urandom;
    return d;
  endfunction

  function automatic ins_t mk(input logic rw, input logic mr, input logic [1:0] op,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2);
    ins_t d = '0;
    d.valid = 1'b1;
    d.rw = rw; d.m2r = mr; d.mr = mr; d.as = mr; d.op = op;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.d1 = d1; d.d2 = d2;
    d.imm = 32'h40; d.pc = 32'h1000;
    return d;
  endfunction

  // monitor: stall is sampled before the edge, registered outputs after it
  initial begin
    exp_t e;
    logic s, ss;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        s  = bus.stall;
        ss = sbus.stall;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("stall", 32'(s), 32'(e.stall));
        chk("stall_small", 32'(ss), 32'(e.stall));
        chk("ex_valid", 32'(got.valid), 32'(e.ex.valid));
        chk("ex_ctrl", 32'({got.rw, got.m2r, got.mr, got.mw, got.as, got.br, got.op}),
            32'({e.ex.rw, e.ex.m2r, e.ex.mr, e.ex.mw, e.ex.as, e.ex.br, e.ex.op}));
        if (e.chk_data) begin
          chk("ex_fields", 32'({got.rs1, got.rs2, got.rd, got.f3, got.f7}),
              32'({e.ex.rs1, e.ex.rs2, e.ex.rd, e.ex.f3, e.ex.f7}));
          chk("ex_rs1_data", got.d1, e.ex.d1);
          chk("ex_rs2_data", got.d2, e.ex.d2);
          chk("ex_imm", got.imm, e.ex.imm);
          chk("ex_pc", got.pc, e.ex.pc);
        end
        chk("ex_valid_small", 32'(sgot.valid), 32'(e.ex.valid));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(sat(e.sc, 65535)));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(sat(e.fc, 65535)));
        chk("stall_cnt_sat", 32'(sbus.stall_cnt), 32'(sat(e.sc, 3)));
        chk("flush_cnt_sat", 32'(sbus.flush_cnt), 32'(sat(e.fc, 3)));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_t d;
    logic fl;
    // reset with random inputs, then first edge after release captures
    step(rand_ins(), 1'b0, 1'b1);
    step(rand_ins(), 1'b0, 1'b1);
    step(rand_ins(), 1'b0, 1'b0);
    // R-type pass-through
    step(mk(1'b1, 1'b0, 2'b10, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd3, 5'd4, 5'd6, 32'h33, 32'h44), 1'b0, 1'b0);
    // load-use: stall once, then capture the held add
    step(mk(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd7, 32'h100, 32'h0), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd6, 5'd7, 5'd8, 32'h5, 32'h6), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd6, 5'd7, 5'd8, 32'h5, 32'h6), 1'b0, 1'b0);
    // load to x0 then use x0; R-type rd=7 then use x7
    step(mk(1'b1, 1'b1, 2'b00, 5'd1, 5'd1, 5'd0, 32'h7, 32'h0), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd0, 5'd0, 5'd9, 32'h8, 32'h9), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd1, 5'd2, 5'd7, 32'ha, 32'hb), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd7, 5'd7, 5'd3, 32'hc, 32'hd), 1'b0, 1'b0);
    // hazard and flush together: flush wins
    step(mk(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd9, 32'he, 32'h0), 1'b0, 1'b0);
    step(mk(1'b1, 1'b0, 2'b10, 5'd9, 5'd3, 5'd4, 32'hf, 32'h1), 1'b1, 1'b0);
    // saturation: fresh counters, five flushes
    step(rand_ins(), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(rand_ins(), 1'b1, 1'b0);
    step(rand_ins(), 1'b0, 1'b0);
    // randomized traffic; decode holds its instruction while stalled
    d = rand_ins();
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) d = rand_ins();
      fl = ($urandom_range(0, 99) < 10);
      step(d, fl, ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
